stack_cmd_ctrl: RTL and testbench

//  Command front-end sitting directly upstream of the 8-bit LIFO stack. Accepts a

---
 rtl/stack_pkg.sv | 19 +
 rtl/stack_cmd_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_cmd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared constants for the LIFO stack and its command front-end.
// Both modules draw their width and depth defaults from here.
package stack_pkg;

  localparam int STK_DATA_W = 8;
  localparam int STK_DEPTH  = 16;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DO_PUSH = 3'd1,
    DO_POP  = 3'd2,
    CAPT    = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/stack_cmd_ctrl.sv
// PUSH/POP command front-end for the LIFO stack: issues single-cycle push/pop pulses,
// tracks occupancy, and returns one registered response per command.
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = STK_DATA_W,
  parameter int DEPTH  = STK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_pop,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_empty,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              desync,
  output logic [2:0]        state_dbg
);

  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a response is held stable until it transfers.

  state_t            state, state_nxt;
  logic              stk_push_nxt, stk_pop_nxt;
  logic [DATA_W-1:0] stk_data_nxt, rsp_data_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, desync_nxt;
  logic              accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign full      = (count == CNT_W'(DEPTH));
  assign state_dbg = state;

  always_comb begin
    state_nxt     = state;
    stk_push_nxt  = 1'b0;
    stk_pop_nxt   = 1'b0;
    stk_data_nxt  = stk_data;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    desync_nxt    = desync;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_pop == OP_PUSH) begin
            if (!full) begin
              state_nxt    = DO_PUSH;
              stk_push_nxt = 1'b1;
              stk_data_nxt = cmd_data;
            end else begin
              state_nxt     = RESP;
              rsp_valid_nxt = 1'b1;
              rsp_err_nxt   = 1'b1;
              rsp_data_nxt  = '0;
            end
          end else begin
            if (count != '0) begin
              state_nxt   = DO_POP;
              stk_pop_nxt = 1'b1;
            end else begin
              state_nxt     = RESP;
              rsp_valid_nxt = 1'b1;
              rsp_err_nxt   = 1'b1;
              rsp_data_nxt  = '0;
            end
          end
        end
      end
      DO_PUSH: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = stk_data;
      end
      DO_POP: begin
        // Our count says non-empty here, so an empty stack means the two disagree.
        state_nxt = CAPT;
        if (stk_empty) desync_nxt = 1'b1;
      end
      CAPT: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = stk_data_out;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      desync    <= 1'b0;
    end else begin
      state     <= state_nxt;
      stk_push  <= stk_push_nxt;
      stk_pop   <= stk_pop_nxt;
      stk_data  <= stk_data_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
      desync    <= desync_nxt;
    end
  end

  // Occupancy moves in the cycle the stack pulse is on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state == DO_PUSH && !full) begin
      count <= count + CNT_W'(1);
    end else if (state == DO_POP && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Bench for stack_cmd_ctrl at DEPTH=4, wired to a small behavioural LIFO.
module tb_stack_cmd_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_pop = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_data, stk_data_out;
  logic          stk_empty;
  logic [2:0]    count;
  logic          full, desync;
  logic [2:0]    state_dbg;
  logic          empty_force = 1'b0;

  always #5 clk = ~clk;

  // Behavioural stack: registered data_out, updated on pop.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [3:0]    sp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp           <= '0;
      stk_data_out <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp[1:0]] <= stk_data;
      sp           <= sp + 4'd1;
    end else if (stk_pop && sp > 0) begin
      stk_data_out <= mem[sp[1:0] - 2'd1];
      sp           <= sp - 4'd1;
    end
  end
  assign stk_empty = (sp == 4'd0) | empty_force;

  stack_cmd_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pop(cmd_pop), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data),
    .stk_data_out(stk_data_out), .stk_empty(stk_empty),
    .count(count), .full(full), .desync(desync), .state_dbg(state_dbg)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] model_q [$];

  int lat, push_n, pop_n, push_cyc, pop_cyc;
  logic [DW-1:0] push_data;

  // Scoreboard: compare each transferred response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: got err=%0b data=%h, none expected", rsp_err, rsp_data);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== e)
          $display("FAIL scoreboard_rsp: got err=%0b data=%h, expected err=%0b data=%h",
                   rsp_err, rsp_data, e[DW], e[DW-1:0]);
        else pass_cnt++;
      end
    end
  end

  // Driver: all bench activity happens 1 time unit after a rising edge.
  task automatic issue(input logic pop, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_pop   = pop;
    cmd_data  = d;
    if (!pop) begin
      if (model_q.size() == DEPTH) exp_q.push_back({1'b1, 8'h00});
      else begin
        model_q.push_back(d);
        exp_q.push_back({1'b0, d});
      end
    end else begin
      if (model_q.size() == 0) exp_q.push_back({1'b1, 8'h00});
      else begin
        exp_q.push_back({1'b0, model_q[$]});
        void'(model_q.pop_back());
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = -1; push_n = 0; pop_n = 0; push_cyc = -1; pop_cyc = -1; push_data = '0;
    for (int i = 1; i <= 10; i++) begin
      if (stk_push) begin push_n++; if (push_cyc < 0) push_cyc = i; push_data = stk_data; end
      if (stk_pop) begin pop_n++; if (pop_cyc < 0) pop_cyc = i; end
      if (rsp_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, full, desync} !== 7'b1000000)
      $display("FAIL reset_flags: got %b, expected 1000000",
               {cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, full, desync});
    else pass_cnt++;
    total_cnt++;
    if ({rsp_data, stk_data} !== 16'h0000)
      $display("FAIL reset_data: got rsp_data=%h stk_data=%h, expected 00 00", rsp_data, stk_data);
    else pass_cnt++;
    total_cnt++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d, expected 0", count);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d, expected 0", state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_push();
    issue(1'b0, 8'hA4);
    total_cnt++;
    if (lat !== 2) $display("FAIL push_latency: got %0d, expected 2", lat); else pass_cnt++;
    total_cnt++;
    if (push_n !== 1 || push_cyc !== 1 || push_data !== 8'hA4)
      $display("FAIL push_pulse: got n=%0d cyc=%0d data=%h, expected n=1 cyc=1 data=a4",
               push_n, push_cyc, push_data);
    else pass_cnt++;
    finish_rsp();
    total_cnt++;
    if (count !== 3'd1 || cmd_ready !== 1'b1)
      $display("FAIL push_count: got count=%0d ready=%0b, expected 1 1", count, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_pop();
    issue(1'b1, 8'h00);
    total_cnt++;
    if (lat !== 3) $display("FAIL pop_latency: got %0d, expected 3", lat); else pass_cnt++;
    total_cnt++;
    if (pop_n !== 1 || pop_cyc !== 1 || push_n !== 0)
      $display("FAIL pop_pulse: got pop_n=%0d cyc=%0d push_n=%0d, expected 1 1 0", pop_n, pop_cyc, push_n);
    else pass_cnt++;
    finish_rsp();
    total_cnt++;
    if (count !== 3'd0) $display("FAIL pop_count: got %0d, expected 0", count); else pass_cnt++;
  endtask

  task automatic test_underflow();
    issue(1'b1, 8'h5A);
    total_cnt++;
    if (lat !== 1 || pop_n !== 0)
      $display("FAIL underflow: got lat=%0d pop_n=%0d, expected 1 0", lat, pop_n);
    else pass_cnt++;
    finish_rsp();
    total_cnt++;
    if (count !== 3'd0) $display("FAIL underflow_count: got %0d, expected 0", count); else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) begin
      issue(1'b0, 8'(i));
      finish_rsp();
    end
    total_cnt++;
    if (full !== 1'b1 || count !== 3'd4)
      $display("FAIL full_set: got full=%0b count=%0d, expected 1 4", full, count);
    else pass_cnt++;
    issue(1'b0, 8'h05);
    total_cnt++;
    if (lat !== 1 || push_n !== 0)
      $display("FAIL overflow: got lat=%0d push_n=%0d, expected 1 0", lat, push_n);
    else pass_cnt++;
    finish_rsp();
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 8'($urandom_range(0, 255)));
      finish_rsp();
    end
    total_cnt++;
    if (full !== 1'b0 || count !== 3'd0)
      $display("FAIL full_drain: got full=%0b count=%0d, expected 0 0", full, count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b0, 8'hC2);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hC2 || rsp_err !== 1'b0 || cmd_ready !== 1'b0)
        $display("FAIL hold_%0d: got valid=%0b data=%h err=%0b ready=%0b, expected 1 c2 0 0",
                 i, rsp_valid, rsp_data, rsp_err, cmd_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL hold_release: got valid=%0b ready=%0b, expected 0 1", rsp_valid, cmd_ready);
    else pass_cnt++;
    issue(1'b1, 8'h00);
    finish_rsp();
  endtask

  task automatic test_reset_mid_pop();
    issue(1'b0, 8'h11);
    finish_rsp();
    cmd_valid = 1'b1; cmd_pop = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total_cnt++;
    if (state_dbg !== 3'd2 || stk_pop !== 1'b1)
      $display("FAIL mid_pop_entry: got state=%0d pop=%0b, expected 2 1", state_dbg, stk_pop);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_q.delete();
    total_cnt++;
    if ({stk_pop, rsp_valid, cmd_ready, count, state_dbg} !== {1'b0, 1'b0, 1'b1, 3'd0, 3'd0})
      $display("FAIL mid_pop_reset: got pop=%0b valid=%0b ready=%0b count=%0d state=%0d, expected 0 0 1 0 0",
               stk_pop, rsp_valid, cmd_ready, count, state_dbg);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL mid_pop_no_rsp: got valid=%0b, expected 0", rsp_valid);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_desync();
    issue(1'b0, 8'h33);
    finish_rsp();
    total_cnt++;
    if (desync !== 1'b0) $display("FAIL desync_clear: got %0b, expected 0", desync); else pass_cnt++;
    empty_force = 1'b1;
    issue(1'b1, 8'h00);
    total_cnt++;
    if (lat !== 3) $display("FAIL desync_latency: got %0d, expected 3", lat); else pass_cnt++;
    finish_rsp();
    empty_force = 1'b0;
    total_cnt++;
    if (desync !== 1'b1 || count !== 3'd0)
      $display("FAIL desync_set: got desync=%0b count=%0d, expected 1 0", desync, count);
    else pass_cnt++;
    issue(1'b0, 8'h44);
    finish_rsp();
    issue(1'b1, 8'h00);
    finish_rsp();
    total_cnt++;
    if (desync !== 1'b1) $display("FAIL desync_sticky: got %0b, expected 1", desync); else pass_cnt++;
  endtask

  initial begin
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_push();
    test_pop();
    test_underflow();
    test_full();
    test_backpressure();
    test_reset_mid_pop();
    test_desync();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
